// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited sequential fetch into a {pc, instr} FIFO with redirect.
// Optional HALT opcode support is enabled by defining IFU_HALT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          halt_pending;
  logic          halt_r;
  logic          halt_hit;
  logic          fetch;
  logic          enq;
  logic          deq;

  // Credits count the in-flight response so the FIFO can never overflow.
  assign fetch = !rst && !redirect && !halt_pending && !halt_hit &&
                 ((count + CW'(inflight)) < DEPTH_C);
  assign enq   = inflight && !redirect;
  assign deq   = instr_valid && instr_ready;

  assign imem_req    = fetch;
  assign imem_addr   = rst ? RESET_PC : pc;
  assign instr_valid = !rst && (count != '0);
  assign instr       = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : '0;
  assign halt        = !rst && halt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= fetch;
      if (fetch) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
      end
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef IFU_HALT_EN
  // Blocking the fetch in the enqueue cycle keeps the HALT word as the last FIFO entry.
  assign halt_hit = inflight && (imem_rdata[31:26] == 6'b111111);

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      halt_pending <= 1'b0;
      halt_r       <= 1'b0;
    end else begin
      if (halt_hit) halt_pending <= 1'b1;
      if (halt_pending && deq && (count == ONE_C)) halt_r <= 1'b1;
    end
  end
`else
  assign halt_hit     = 1'b0;
  assign halt_pending = 1'b0;
  assign halt_r       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scenario tasks plus a request/delivery scoreboard model.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFU_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_deliv = 0;
  int cyc     = 0;
  bit plant_halt = 1'b0;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } ent_t;

  // Requested-but-undelivered fetches in request order, with the cycle of request.
  ent_t        q[$];
  logic [31:0] next_fetch = RESET_PC;
  bit          halt_lat = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  logic [31:0] prev_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (plant_halt && a == 32'h8) return 32'hFC00_0000;
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic bit is_halt(input logic [31:0] a);
    return HALT_EN && plant_halt && (a == 32'h8);
  endfunction

  function automatic bit halt_in_q();
    foreach (q[i]) if (is_halt(q[i].pc)) return 1'b1;
    return 1'b0;
  endfunction

  // Memory answers exactly one cycle after a request; otherwise drives junk.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
    else          imem_rdata <= $urandom;
  end

  task automatic run_cycle(input bit r, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit exp_req, exp_valid, hit_halt;
    ent_t e;
    @(negedge clk);
    rst = r; instr_ready = rdy; redirect = redir; redirect_pc = rpc;
    #1;
    cyc++;
    if (r) halt_lat = 1'b0;
    exp_req   = !r && !redir && !halt_lat && !halt_in_q() && (q.size() < DEPTH);
    exp_valid = !r && (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
    n_tests++;
    if (imem_req !== exp_req) begin
      n_fail++; $display("FAIL imem_req cyc=%0d got=%b want=%b", cyc, imem_req, exp_req);
    end
    n_tests++;
    if (instr_valid !== exp_valid) begin
      n_fail++; $display("FAIL instr_valid cyc=%0d got=%b want=%b", cyc, instr_valid, exp_valid);
    end
    n_tests++;
    if (halt !== halt_lat) begin
      n_fail++; $display("FAIL halt cyc=%0d got=%b want=%b", cyc, halt, halt_lat);
    end
    if (imem_req && exp_req) begin
      n_tests++;
      if (imem_addr !== next_fetch) begin
        n_fail++; $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr, next_fetch);
      end
    end
    if (r) begin
      n_tests++;
      if (imem_addr !== RESET_PC || instr !== 32'h0 || instr_pc !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got addr=%h instr=%h pc=%h want addr=%h instr=0 pc=0",
                 cyc, imem_addr, instr, instr_pc, RESET_PC);
      end
    end
    hit_halt = 1'b0;
    if (exp_valid && instr_valid && rdy) begin
      n_tests++;
      if (instr_pc !== q[0].pc || instr !== mem_word(q[0].pc)) begin
        n_fail++;
        $display("FAIL deliver cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                 cyc, instr_pc, instr, q[0].pc, mem_word(q[0].pc));
      end
      hit_halt = is_halt(q[0].pc);
      void'(q.pop_front());
      n_deliv++;
    end
    if (prev_stall && !r) begin
      n_tests++;
      if (instr !== prev_instr || instr_pc !== prev_pc) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                 cyc, instr_pc, instr, prev_pc, prev_instr);
      end
    end
    prev_stall = !r && !redir && instr_valid && !rdy;
    prev_instr = instr;
    prev_pc    = instr_pc;
    if (r) begin
      q.delete(); next_fetch = RESET_PC;
    end else if (redir) begin
      q.delete(); next_fetch = rpc; halt_lat = 1'b0;
    end else begin
      if (imem_req) begin
        e.pc = next_fetch; e.cyc = cyc;
        q.push_back(e);
        next_fetch = next_fetch + 32'd4;
      end
      if (hit_halt) halt_lat = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    n_tests++;
    if (instr_valid !== 1'b0 || halt !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold got valid=%b halt=%b req=%b want 0 0 0", instr_valid, halt, imem_req);
    end
  endtask

  task automatic test_stream();
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 12; k++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (k == 0) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
          n_fail++; $display("FAIL first_req got req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC);
        end
      end
      n_tests++;
      if (instr_valid !== (k >= 2)) begin
        n_fail++; $display("FAIL stream_valid k=%0d got=%b want=%b", k, instr_valid, (k >= 2));
      end
      if (k >= 2) begin
        n_tests++;
        if (instr_pc !== 32'(4 * (k - 2))) begin
          n_fail++; $display("FAIL stream_pc k=%0d got=%h want=%h", k, instr_pc, 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    int reqs;
    logic [31:0] first_addr;
    bit seen;
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    reqs = 0;
    for (int k = 0; k < 10; k++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      if (imem_req) reqs++;
    end
    n_tests++;
    if (reqs !== DEPTH || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL stall_credits got reqs=%0d req=%b want %0d 0", reqs, imem_req, DEPTH);
    end
    seen = 1'b0; first_addr = 32'h0;
    for (int k = 0; k < 10; k++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (imem_req && !seen) begin seen = 1'b1; first_addr = imem_addr; end
    end
    n_tests++;
    if (!seen || first_addr !== 32'h10) begin
      n_fail++; $display("FAIL stall_resume got seen=%b addr=%h want 1 00000010", seen, first_addr);
    end
  endtask

  task automatic test_redirect();
    bit got;
    logic [31:0] first_pc;
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_next got valid=%b req=%b addr=%h want 0 1 00000100", instr_valid, imem_req, imem_addr);
    end
    got = 1'b0; first_pc = 32'h0;
    for (int k = 0; k < 6; k++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (instr_valid && !got) begin got = 1'b1; first_pc = instr_pc; end
    end
    n_tests++;
    if (!got || first_pc !== 32'h100) begin
      n_fail++; $display("FAIL redirect_first got seen=%b pc=%h want 1 00000100", got, first_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [4];
    int n;
    exp_seq[0] = 32'hFFFF_FFF8; exp_seq[1] = 32'hFFFF_FFFC;
    exp_seq[2] = 32'h0000_0000; exp_seq[3] = 32'h0000_0004;
    run_cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (imem_req && n < 4) begin
        n_tests++;
        if (imem_addr !== exp_seq[n]) begin
          n_fail++; $display("FAIL wrap_seq idx=%0d got=%h want=%h", n, imem_addr, exp_seq[n]);
        end
        n++;
      end
    end
    n_tests++;
    if (n !== 4) begin
      n_fail++; $display("FAIL wrap_count got=%0d want=4", n);
    end
  endtask

  task automatic test_halt();
    bit saw_c;
    plant_halt = 1'b1;
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    saw_c = 1'b0;
    for (int k = 0; k < 8; k++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (imem_req && imem_addr == 32'hC) saw_c = 1'b1;
    end
    n_tests++;
    if (halt !== HALT_EN || saw_c !== !HALT_EN) begin
      n_fail++; $display("FAIL halt_stop got halt=%b fetched_c=%b want %b %b", halt, saw_c, HALT_EN, !HALT_EN);
    end
    run_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (halt !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL halt_redirect got halt=%b req=%b addr=%h want 0 1 00000040", halt, imem_req, imem_addr);
    end
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    plant_halt = 1'b0;
  endtask

  task automatic test_reset_midstream();
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 7; k++) run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    n_tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halt !== 1'b0 || instr !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset got req=%b valid=%b halt=%b instr=%h want 0 0 0 0", imem_req, instr_valid, halt, instr);
    end
    run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL mid_restart got valid=%b req=%b addr=%h want 0 1 %h", instr_valid, imem_req, imem_addr, RESET_PC);
    end
    for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    int start;
    start = n_deliv;
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 65),
                ($urandom_range(0, 99) < 5), $urandom & 32'h00FF_FFFC);
    end
    n_tests++;
    if (n_deliv - start < 50) begin
      n_fail++; $display("FAIL random_progress got=%0d want>=50", n_deliv - start);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter: FIFO_DEPTH, 4, instruction buffer entries; power of two, >=2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: imem_req  output  1  instruction memory read request.
REQ-006 Port: imem_addr  output  32  byte address of the request; valid while imem_req=1.
REQ-007 Port: imem_rdata  input  32  read data; valid exactly one cycle after the imem_req cycle.
REQ-008 Port: instr  output  32  instruction at FIFO head: opcode [31:26], rs [25:22], rt [21:18], rd [17:14], funct [8:3], imm16 [17:2].
REQ-009 Port: instr_pc  output  32  address of instr.
REQ-010 Port: instr_valid  output  1  FIFO head valid.
REQ-011 Port: instr_ready  input  1  consumer accepts head when instr_valid & instr_ready.
REQ-012 Port: redirect  input  1  one-cycle PC redirect strobe.
REQ-013 Port: redirect_pc  input  32  new fetch address; sampled when redirect=1.
REQ-014 Port: halt  output  1  fetch stopped on HALT opcode.

Function
REQ-015 The block SHALL keep a fetch PC, an in-flight flag and a FIFO_DEPTH-entry FIFO of {pc, instruction}.
REQ-016 imem_req SHALL be 1 iff not halt_pending, redirect=0, and (FIFO count + in-flight) < FIFO_DEPTH; imem_addr = PC.
REQ-017 Each request cycle PC SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 The cycle after a request, imem_rdata and its PC SHALL be written into the FIFO unless squashed; the entry is visible on instr/instr_valid the following cycle (request at N -> instr_valid at N+2).
REQ-019 Dequeue SHALL occur on instr_valid & instr_ready; simultaneous enqueue and dequeue SHALL keep count unchanged; FIFO never overflows (credit rule REQ-016).
REQ-020 instr, instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-021 Fetch order SHALL equal delivery order; no instruction duplicated or dropped except by redirect.
REQ-022 On redirect=1: FIFO flushed (instr_valid=0 next cycle), in-flight response squashed, PC <= redirect_pc, no request that cycle; first request to redirect_pc in the next cycle.
REQ-023 Redirect SHALL take priority over enqueue, dequeue, and halt; it clears halt_pending and halt.
REQ-024 A dequeue coinciding with redirect SHALL complete (consumer saw it); all remaining entries discarded.

Reset
REQ-025 While rst=1: PC=RESET_PC, FIFO empty, in-flight cleared, halt_pending=0; outputs imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halt=0.
REQ-026 rst SHALL override redirect; a response to a request issued before rst SHALL be discarded.
REQ-027 First request SHALL occur in the first cycle with rst=0.

Configuration
REQ-028 Macro IFU_HALT_EN: when defined, enqueueing opcode 6'b111111 sets halt_pending (no further requests); halt=1 from the cycle after that instruction is dequeued, held until redirect or rst.
REQ-029 Without IFU_HALT_EN: opcode 6'b111111 is an ordinary instruction; halt tied 0; halt_pending never set.

Verification
REQ-030 Reset release, instr_ready=1, memory returns addr^32'hA5A5_0000 -> imem_addr 0,4,8..., instr_valid first at cycle 2, one instruction per cycle, instr_pc matches.
REQ-031 instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH (4) requests issued, imem_req=0 after, instr/instr_pc stable; on release, 4 buffered entries drain in order, fetching resumes at 0x10.
REQ-032 redirect=1, redirect_pc=32'h0000_0100 with 3 entries buffered and one in flight -> next cycle instr_valid=0, imem_addr=0x100, first delivered instr_pc=0x100; squashed data never appears.
REQ-033 redirect_pc=32'hFFFF_FFF8 -> fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-034 IFU_HALT_EN defined, word 0xFC000000 at address 0x8 -> no request after it, halt=1 the cycle after its dequeue; redirect to 0x40 clears halt and fetches 0x40. Undefined: fetching continues at 0xC, halt=0.
REQ-035 rst asserted one cycle mid-stream with FIFO full -> next cycle all outputs at reset values; fetch restarts at RESET_PC.
